// File: rtl/npc_path_sequencer.sv
// npc_path_sequencer: table-driven per-enemy motion script with partner sync,
// life/hurt tracking and a frame-clocked run/halt/dead state machine.
module npc_path_sequencer #(
    parameter int          SEG_DEPTH   = 16,
    parameter int          ADDR_W      = $clog2(SEG_DEPTH),
    parameter int          POS_W       = 10,
    parameter int          X_MIN       = 0,
    parameter int          X_MAX       = 639,
    parameter int          Y_MIN       = 0,
    parameter int          Y_MAX       = 328,
    parameter int          X_HOME      = 324,
    parameter int          Y_HOME      = 110,
    parameter int          SIZE_X      = 63,
    parameter int          SIZE_Y      = 160,
    parameter logic [7:0]  START_KEY   = 8'h2C,
    parameter int          LIFE_INIT   = 10,
    parameter int          HURT_FRAMES = 8,
    parameter int          LOOP        = 0
) (
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic [7:0]        keycode,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [25:0]       cfg_data,
    input  logic              sync_in,
    input  logic              hit,
    output logic [POS_W-1:0]  enemy_x,
    output logic [POS_W-1:0]  enemy_y,
    output logic [POS_W-1:0]  enemy_size_x,
    output logic [POS_W-1:0]  enemy_size_y,
    output logic [2:0]        seq_state,
    output logic [ADDR_W-1:0] seg_idx,
    output logic [3:0]        life,
    output logic              hurt,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, WAIT_SYNC = 3'd2, HALT = 3'd3, DEAD = 3'd4} state_t;
    localparam logic [1:0] M_MOVE = 2'd0, M_WAIT = 2'd1, M_TELE = 2'd2;
    localparam int HW = $clog2(HURT_FRAMES + 1);
    localparam logic [POS_W+1:0] XH = (POS_W+2)'(X_HOME);
    localparam logic [POS_W+1:0] YH = (POS_W+2)'(Y_HOME);

    logic [25:0]       r_table [SEG_DEPTH];
    state_t            r_state;
    logic [POS_W-1:0]  r_x, r_y;
    logic [ADDR_W-1:0] r_seg;
    logic [7:0]        r_cnt;
    logic [3:0]        r_life;
    logic [HW-1:0]     r_hurt;

    logic [25:0]             w_seg;
    logic [1:0]              w_mode;
    logic [7:0]              w_len, w_dy, w_dx;
    logic                    w_last, w_start, w_hit_ok, w_kill;
    logic [ADDR_W-1:0]       w_next;
    logic signed [POS_W+1:0] w_mx, w_my, w_tx, w_ty;

    function automatic logic [POS_W-1:0] clamp(input logic signed [POS_W+1:0] v, input int lo, input int hi);
        return (v < lo) ? POS_W'(lo) : (v > hi) ? POS_W'(hi) : v[POS_W-1:0];
    endfunction

    assign w_seg    = r_table[r_seg];
    assign {w_mode, w_len, w_dy, w_dx} = w_seg;
    assign w_last   = (w_len <= 8'd1) || (r_cnt == w_len - 8'd1);
    assign w_next   = (r_seg == ADDR_W'(SEG_DEPTH - 1)) ? '0 : r_seg + 1'b1;
    assign w_start  = keycode == START_KEY;
    assign w_hit_ok = hit && (r_state == RUN || r_state == WAIT_SYNC || r_state == HALT);
    assign w_kill   = r_life <= 4'd1;
    // Step and teleport targets use two guard bits so under/overflow is visible to the clamp
    assign w_mx     = {2'b00, r_x} + {{(POS_W-6){w_dx[7]}}, w_dx};
    assign w_my     = {2'b00, r_y} + {{(POS_W-6){w_dy[7]}}, w_dy};
    assign w_tx     = XH + {{(POS_W-8){w_dx[7]}}, w_dx, 2'b00};
    assign w_ty     = YH + {{(POS_W-8){w_dy[7]}}, w_dy, 2'b00};

    always_ff @(posedge frame_clk)
        if (cfg_we && (r_state == IDLE || r_state == HALT)) r_table[cfg_addr] <= cfg_data;

    always_ff @(posedge frame_clk or posedge Reset)
        if (Reset) begin
            r_state <= IDLE;
            r_x     <= POS_W'(X_HOME);
            r_y     <= POS_W'(Y_HOME);
            r_seg   <= '0;
            r_cnt   <= '0;
            r_life  <= 4'(LIFE_INIT);
            r_hurt  <= '0;
        end else begin
            r_hurt <= (r_hurt != '0) ? r_hurt - 1'b1 : '0;
            if (w_hit_ok) begin
                r_life <= (r_life != 4'd0) ? r_life - 1'b1 : 4'd0;
                r_hurt <= HW'(HURT_FRAMES);
            end
            // A fatal hit overrides whatever the script would have done this frame
            if (w_hit_ok && w_kill) begin
                r_state <= DEAD;
                r_hurt  <= '0;
            end else
                case (r_state)
                    IDLE, HALT:
                        if (w_start) begin
                            r_state <= RUN;
                            r_seg   <= '0;
                            r_cnt   <= '0;
                        end
                    RUN, WAIT_SYNC:
                        case (w_mode)
                            M_MOVE: begin
                                r_x   <= clamp(w_mx, X_MIN, X_MAX);
                                r_y   <= clamp(w_my, Y_MIN, Y_MAX);
                                r_cnt <= w_last ? 8'd0 : r_cnt + 1'b1;
                                if (w_last) r_seg <= w_next;
                            end
                            M_WAIT: begin
                                r_state <= sync_in ? RUN : WAIT_SYNC;
                                if (sync_in) r_seg <= w_next;
                            end
                            M_TELE: begin
                                r_x   <= clamp(w_tx, X_MIN, X_MAX);
                                r_y   <= clamp(w_ty, Y_MIN, Y_MAX);
                                r_seg <= w_next;
                            end
                            default: begin
                                r_state <= (LOOP != 0) ? RUN : HALT;
                                r_cnt   <= '0;
                                if (LOOP != 0) r_seg <= '0;
                            end
                        endcase
                    default: r_hurt <= '0;
                endcase
        end

    assign enemy_x      = r_x;
    assign enemy_y      = r_y;
    assign enemy_size_x = POS_W'(SIZE_X);
    assign enemy_size_y = POS_W'(SIZE_Y);
    assign seq_state    = r_state;
    assign seg_idx      = r_seg;
    assign life         = r_life;
    assign hurt         = r_hurt != '0;
    assign busy         = (r_state == RUN) || (r_state == WAIT_SYNC);
endmodule

// File: tb/tb_npc_path_sequencer.sv
// tb_npc_path_sequencer: scoreboard bench driving a halting (LIFE_INIT=2) and a looping instance
// from shared stimulus; expected values are queued by frame and checked by a negedge monitor.
module tb_npc_path_sequencer;
    localparam int AX = 0, AY = 1, AST = 2, ASEG = 3, ALIFE = 4, AHURT = 5, ABUSY = 6,
                   BX = 7, BY = 8, BST = 9, BSEG = 10, BLIFE = 11, ASX = 12, ASY = 13;

    logic        frame_clk = 1'b0, Reset = 1'b1, cfg_we = 1'b0, sync_in = 1'b0, hit = 1'b0;
    logic [7:0]  keycode = 8'h00;
    logic [3:0]  cfg_addr = 4'd0;
    logic [25:0] cfg_data = 26'd0;
    logic [9:0]  a_x, a_y, a_sx, a_sy, b_x, b_y, b_sx, b_sy;
    logic [2:0]  a_st, b_st;
    logic [3:0]  a_seg, b_seg, a_life, b_life;
    logic        a_hurt, b_hurt, a_busy, b_busy;

    npc_path_sequencer #(.LIFE_INIT(2)) u_a (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .sync_in(sync_in), .hit(hit),
        .enemy_x(a_x), .enemy_y(a_y), .enemy_size_x(a_sx), .enemy_size_y(a_sy),
        .seq_state(a_st), .seg_idx(a_seg), .life(a_life), .hurt(a_hurt), .busy(a_busy));

    npc_path_sequencer #(.LOOP(1)) u_b (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .sync_in(sync_in), .hit(hit),
        .enemy_x(b_x), .enemy_y(b_y), .enemy_size_x(b_sx), .enemy_size_y(b_sy),
        .seq_state(b_st), .seg_idx(b_seg), .life(b_life), .hurt(b_hurt), .busy(b_busy));

    always #5 frame_clk = ~frame_clk;

    int fr = 0;
    always @(posedge frame_clk) fr <= fr + 1;

    typedef struct packed {int f; int sel; int val;} exp_t;
    exp_t q[$];
    int total = 0, bad = 0;

    function automatic int get(input int s);
        case (s)
            AX: return int'(a_x);
            AY: return int'(a_y);
            AST: return int'(a_st);
            ASEG: return int'(a_seg);
            ALIFE: return int'(a_life);
            AHURT: return int'(a_hurt);
            ABUSY: return int'(a_busy);
            BX: return int'(b_x);
            BY: return int'(b_y);
            BST: return int'(b_st);
            BSEG: return int'(b_seg);
            BLIFE: return int'(b_life);
            ASX: return int'(a_sx);
            ASY: return int'(a_sy);
            default: return -1;
        endcase
    endfunction

    function automatic string nm(input int s);
        case (s)
            AX: return "a_x";
            AY: return "a_y";
            AST: return "a_state";
            ASEG: return "a_seg";
            ALIFE: return "a_life";
            AHURT: return "a_hurt";
            ABUSY: return "a_busy";
            BX: return "b_x";
            BY: return "b_y";
            BST: return "b_state";
            BSEG: return "b_seg";
            BLIFE: return "b_life";
            ASX: return "a_size_x";
            ASY: return "a_size_y";
            default: return "unknown";
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge frame_clk);
        #1;
    endtask

    // Queue an expectation for d frames from now, kept sorted by frame
    task automatic chk(input int d, input int s, input int v);
        exp_t e;
        int i = 0;
        e = '{f: fr + d, sel: s, val: v};
        while (i < q.size() && q[i].f <= e.f) i++;
        q.insert(i, e);
    endtask

    task automatic wr(input int a, input logic [1:0] m, input logic [7:0] l, input logic [7:0] dy, input logic [7:0] dx);
        cfg_we = 1'b1;
        cfg_addr = 4'(a);
        cfg_data = {m, l, dy, dx};
        step(1);
        cfg_we = 1'b0;
    endtask

    task automatic go();
        keycode = 8'h2C;
        step(1);
        keycode = 8'h00;
    endtask

    always @(negedge frame_clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].f <= fr) begin
            e = q.pop_front();
            total++;
            if (e.f < fr || get(e.sel) != e.val) begin
                bad++;
                $display("FAIL %s frame %0d: got %0d want %0d", nm(e.sel), e.f, get(e.sel), e.val);
            end
        end
    end

    initial begin
        step(2);
        Reset = 1'b0;
        // straight move then END; A halts, B loops
        wr(0, 2'd0, 8'd4, 8'hF8, 8'hFC);
        wr(1, 2'd3, 8'd0, 8'd0, 8'd0);
        chk(0, AX, 324); chk(0, AY, 110); chk(0, AST, 0); chk(0, ASEG, 0); chk(0, ALIFE, 2);
        chk(0, AHURT, 0); chk(0, ABUSY, 0); chk(0, ASX, 63); chk(0, ASY, 160); chk(0, BLIFE, 10);
        go();
        chk(0, AST, 1); chk(0, ABUSY, 1); chk(4, AX, 308); chk(4, AY, 78); chk(4, ASEG, 1);
        chk(5, AST, 3); chk(5, ABUSY, 0); chk(5, BST, 1); chk(5, BSEG, 0); chk(8, AX, 308);
        step(8);
        // A accepts the write in HALT; B is busy and must keep the old script
        wr(0, 2'd0, 8'd14, 8'd19, 8'd0);
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        go();
        chk(1, AY, 129); chk(10, AY, 300); chk(11, AY, 319); chk(12, AY, 328); chk(13, ASEG, 0);
        chk(14, AY, 328); chk(14, ASEG, 1); chk(15, AST, 3); chk(4, BX, 308); chk(4, BY, 78);
        step(15);
        // wait for partner then teleport; restart from HALT keeps position
        wr(0, 2'd1, 8'd0, 8'd0, 8'd0);
        wr(1, 2'd2, 8'd0, 8'hF9, 8'h3F);
        wr(2, 2'd3, 8'd0, 8'd0, 8'd0);
        go();
        chk(0, AY, 328); chk(1, AST, 2); chk(20, AST, 2); chk(20, AY, 328); chk(20, ABUSY, 1); chk(20, ASEG, 0);
        step(20);
        sync_in = 1'b1;
        step(1);
        sync_in = 1'b0;
        chk(0, ASEG, 1); chk(0, AST, 1); chk(0, AX, 324); chk(1, AX, 576); chk(1, AY, 82); chk(2, AST, 3);
        step(2);
        // non-fatal hit in HALT
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        chk(0, ALIFE, 1); chk(0, AHURT, 1); chk(0, BLIFE, 9); chk(7, AHURT, 1); chk(8, AHURT, 0); chk(8, AST, 3);
        step(8);
        // fatal hit on the frame a MOVE segment would advance
        wr(0, 2'd0, 8'd3, 8'd0, 8'd5);
        wr(1, 2'd3, 8'd0, 8'd0, 8'd0);
        go();
        step(2);
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        chk(0, AST, 4); chk(0, ASEG, 0); chk(0, AX, 586); chk(0, ALIFE, 0); chk(0, ABUSY, 0); chk(0, AHURT, 0);
        go();
        chk(0, AST, 4); chk(0, AX, 586);
        step(2);
        // looping instance
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        wr(0, 2'd0, 8'd2, 8'd0, 8'd1);
        wr(1, 2'd3, 8'd0, 8'd0, 8'd0);
        go();
        chk(1, BSEG, 0); chk(2, BSEG, 1); chk(3, BSEG, 0); chk(4, BSEG, 0); chk(5, BSEG, 1); chk(6, BSEG, 0);
        chk(3, BX, 326); chk(6, BX, 328); chk(9, BX, 330); chk(3, AST, 3); chk(3, AX, 326);
        step(10);
        // len 0 segment, async reset mid-move, rerun of the retained table
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        wr(0, 2'd0, 8'd0, 8'd2, 8'hFD);
        wr(1, 2'd0, 8'd5, 8'hFF, 8'd2);
        wr(2, 2'd3, 8'd0, 8'd0, 8'd0);
        go();
        chk(1, AX, 321); chk(1, AY, 112); chk(1, ASEG, 1); chk(3, AX, 325);
        step(1);
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        chk(0, ALIFE, 1); chk(0, AHURT, 1);
        step(2);
        Reset = 1'b1;
        chk(0, AX, 324); chk(0, AY, 110); chk(0, AST, 0); chk(0, ASEG, 0); chk(0, ALIFE, 2);
        chk(0, AHURT, 0); chk(0, ABUSY, 0);
        step(1);
        Reset = 1'b0;
        go();
        chk(1, AX, 321); chk(1, AY, 112); chk(4, AX, 327); chk(4, AY, 109);
        chk(6, AX, 331); chk(6, AY, 107); chk(6, ASEG, 2); chk(7, AST, 3);
        step(8);
        for (int i = 0; i < 50 && q.size() > 0; i++) step(1);
        if (q.size() > 0) begin
            $display("FAIL drain: got %0d pending want 0", q.size());
            bad += q.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
